// File: rtl/vga_win_gen_if.sv
// vga_win_gen_if: ROM address/data pair and composited video output of the window generator.
interface vga_win_gen_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] addra;
    logic [ADDR_W-1:0] addrb;
    logic [PIX_W-1:0]  qa;
    logic [PIX_W-1:0]  qb;
    logic [PIX_W-1:0]  rgb;
    logic              hs;
    logic              vs;
    logic              de;
    modport master (output addra, addrb, hs, vs, de, rgb, input qa, qb);
    modport slave  (input addra, addrb, hs, vs, de, rgb, output qa, qb);
endinterface

// File: rtl/vga_win_gen.sv
// vga_win_gen: programmable VGA timing with a positioned window (image A) and a scaled image B.
module vga_win_gen #(
    parameter int H_SYNC      = 176,
    parameter int H_BACK      = 176,
    parameter int H_ACTIVE    = 1280,
    parameter int H_FRONT     = 16,
    parameter int V_SYNC      = 3,
    parameter int V_BACK      = 28,
    parameter int V_ACTIVE    = 768,
    parameter int V_FRONT     = 1,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int PIX_W       = 8,
    parameter int ADDR_W      = 16,
    parameter int WIN_W       = 170,
    parameter int WIN_H       = 150,
    parameter int SCALE_SHIFT = 3,
    parameter int B_BASE      = 25500,
    parameter int B_ROWS      = 115,
    parameter int ROM_LAT     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_step,
    input  logic [10:0]      win_x,
    input  logic [10:0]      win_y,
    input  logic [PIX_W-1:0] bg,
    vga_win_gen_if.master    bus,
    output logic             frame_start,
    output logic [1:0]       mode
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int CW = 13;
    localparam int X0 = H_SYNC + H_BACK;
    localparam int Y0 = V_SYNC + V_BACK;
    localparam logic [1:0] SEL_BG = 2'd0, SEL_A = 2'd1, SEL_B = 2'd2;

    logic [HW-1:0]            h_cnt;
    logic [VW-1:0]            v_cnt;
    logic [10:0]              wx, wy;
    logic [1:0]               pending;
    logic [ADDR_W-1:0]        row_base;
    logic [ROM_LAT:0]         hs_p, vs_p, de_p;
    logic [ROM_LAT:0][1:0]    sel_p;
    logic                     h_end, v_end, act, in_win, b_ok, row_end;
    logic [CW-1:0]            x, y, col, by;
    logic [1:0]               sel_n;

    assign h_end = h_cnt == HW'(H_TOTAL - 1);
    assign v_end = v_cnt == VW'(V_TOTAL - 1);

    // x/y wrap to large values before the active region, so one unsigned compare bounds each axis
    always_comb begin
        x = CW'(h_cnt) - CW'(X0);
        y = CW'(v_cnt) - CW'(Y0);
        act = x < CW'(H_ACTIVE) && y < CW'(V_ACTIVE);
        col = x - CW'(wx);
        in_win = act && x >= CW'(wx) && col < CW'(WIN_W) && y >= CW'(wy) && (y - CW'(wy)) < CW'(WIN_H);
        row_end = col == CW'(WIN_W - 1) || x == CW'(H_ACTIVE - 1);
        by = y >> SCALE_SHIFT;
        b_ok = act && by < CW'(B_ROWS);
        sel_n = (!mode[0] && in_win) ? SEL_A : ((mode[0] ^ mode[1]) && b_ok) ? SEL_B : SEL_BG;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
            pending     <= '0;
            mode        <= '0;
            wx          <= '0;
            wy          <= '0;
            row_base    <= '0;
            bus.addra   <= '0;
            bus.addrb   <= ADDR_W'(B_BASE);
            hs_p        <= {(ROM_LAT + 1){~HS_POL}};
            vs_p        <= {(ROM_LAT + 1){~VS_POL}};
            de_p        <= '0;
            sel_p       <= '0;
            bus.hs      <= ~HS_POL;
            bus.vs      <= ~VS_POL;
            bus.de      <= 1'b0;
            bus.rgb     <= '0;
        end else begin
            h_cnt <= h_end ? '0 : h_cnt + 1'b1;
            if (h_end) v_cnt <= v_end ? '0 : v_cnt + 1'b1;
            frame_start <= h_cnt == '0 && v_cnt == '0;
            pending <= pending + 2'(mode_step);
            // frame_start never falls inside the window, so restarting addra here cannot collide
            if (frame_start) begin
                mode      <= pending;
                wx        <= win_x;
                wy        <= win_y;
                row_base  <= '0;
                bus.addra <= '0;
            end else if (in_win) begin
                bus.addra <= row_base + ADDR_W'(col);
                if (row_end) row_base <= row_base + ADDR_W'(WIN_W);
            end
            if (b_ok) bus.addrb <= ADDR_W'(B_BASE) + ADDR_W'(32'(by) * (H_ACTIVE >> SCALE_SHIFT)) + ADDR_W'(x >> SCALE_SHIFT);
            hs_p  <= {hs_p[ROM_LAT-1:0], (h_cnt < HW'(H_SYNC)) ? HS_POL : ~HS_POL};
            vs_p  <= {vs_p[ROM_LAT-1:0], (v_cnt < VW'(V_SYNC)) ? VS_POL : ~VS_POL};
            de_p  <= {de_p[ROM_LAT-1:0], act};
            sel_p <= {sel_p[ROM_LAT-1:0], sel_n};
            bus.hs <= hs_p[ROM_LAT];
            bus.vs <= vs_p[ROM_LAT];
            bus.de <= de_p[ROM_LAT];
            bus.rgb <= !de_p[ROM_LAT] ? '0 : sel_p[ROM_LAT] == SEL_A ? bus.qa : sel_p[ROM_LAT] == SEL_B ? bus.qb : bg;
        end
    end
endmodule

// File: tb/tb_vga_win_gen.sv
// tb_vga_win_gen: randomized checks of timing, compositing and mode stepping against a frame-level model.
module tb_vga_win_gen;
    localparam int HS = 4, HB = 6, HA = 48, HF = 2, VS = 2, VB = 3, VA = 40, VF = 1;
    localparam bit HPOL = 1'b1, VPOL = 1'b0;
    localparam int WW = 10, WH = 6, SS = 2, BB = 100, BR = 8, RL = 2;
    localparam int HT = HS + HB + HA + HF, VT = VS + VB + VA + VF, FT = HT * VT, L = RL + 2;

    logic        clk = 1'b0, rst = 1'b1, mode_step = 1'b0, frame_start;
    logic [10:0] win_x = '0, win_y = '0;
    logic [7:0]  bg = '0;
    logic [1:0]  mode;
    logic [15:0] pa [RL];
    logic [15:0] pb [RL];
    int c = 0, pulses = 0, n_cmp = 0, n_fail = 0, nxt_wx = 0, nxt_wy = 0;
    int fr_mode [64], fr_wx [64], fr_wy [64], fr_bg [64];

    vga_win_gen_if #(.PIX_W(8), .ADDR_W(16)) vif ();

    vga_win_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .HS_POL(HPOL), .VS_POL(VPOL), .PIX_W(8), .ADDR_W(16),
        .WIN_W(WW), .WIN_H(WH), .SCALE_SHIFT(SS), .B_BASE(BB), .B_ROWS(BR), .ROM_LAT(RL)
    ) dut (
        .clk(clk), .rst(rst), .mode_step(mode_step), .win_x(win_x), .win_y(win_y), .bg(bg),
        .bus(vif), .frame_start(frame_start), .mode(mode)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_a(input logic [15:0] a);
        return 8'(a * 13 + 7);
    endfunction

    function automatic logic [7:0] rom_b(input logic [15:0] a);
        return 8'(a) ^ 8'h96;
    endfunction

    // synchronous ROMs with RL clocks of read latency
    always @(posedge clk) begin
        pa[0] <= vif.addra;
        pb[0] <= vif.addrb;
        for (int i = 1; i < RL; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end
    assign vif.qa = rom_a(pa[RL-1]);
    assign vif.qb = rom_b(pb[RL-1]);

    // pins at cycle cc show the counter state of cycle cc-L
    function automatic void expect_at(input int cc, output logic ehs, output logic evs,
                                      output logic ede, output logic [7:0] ergb);
        int k, h, v, f, x, y, wx, wy, m;
        bit ina, okb;
        ehs = ~HPOL; evs = ~VPOL; ede = 1'b0; ergb = '0;
        if (cc < L) return;
        k = cc - L; h = k % HT; v = (k / HT) % VT; f = k / FT;
        ehs = (h < HS) ? HPOL : ~HPOL;
        evs = (v < VS) ? VPOL : ~VPOL;
        x = h - (HS + HB); y = v - (VS + VB);
        ede = x >= 0 && x < HA && y >= 0 && y < VA;
        if (!ede) return;
        wx = fr_wx[f]; wy = fr_wy[f]; m = fr_mode[f];
        ina = x >= wx && x < wx + WW && y >= wy && y < wy + WH;
        okb = (y >> SS) < BR;
        if ((m == 0 || m == 2) && ina) ergb = rom_a(16'((y - wy) * WW + x - wx));
        else if ((m == 1 || m == 2) && okb) ergb = rom_b(16'(BB + (y >> SS) * (HA >> SS) + (x >> SS)));
        else ergb = 8'(fr_bg[f]);
    endfunction

    function automatic logic [1:0] exp_mode(input int cc);
        return (cc < 2) ? 2'd0 : 2'(fr_mode[(cc - 2) / FT]);
    endfunction

    function automatic int last_a(input int f);
        int wx, wy;
        wx = fr_wx[f]; wy = fr_wy[f];
        if (wx >= HA || wy >= VA) return 0;
        return (((wy + WH > VA) ? VA : wy + WH) - 1 - wy) * WW + (((wx + WW > HA) ? HA : wx + WW) - 1 - wx);
    endfunction

    // drive one cycle; window/bg only settle on the frame_start cycle, otherwise win is noise
    task automatic tick();
        if (c % FT == 1) begin
            win_x = 11'(nxt_wx); win_y = 11'(nxt_wy); bg = 8'($urandom);
            fr_mode[c / FT] = pulses & 3; fr_wx[c / FT] = nxt_wx; fr_wy[c / FT] = nxt_wy; fr_bg[c / FT] = int'(bg);
        end else begin
            win_x = 11'($urandom); win_y = 11'($urandom);
        end
        if (mode_step) pulses++;
        @(posedge clk);
        c++;
        @(negedge clk);
    endtask

    task automatic goto_mode(input int m);
        int n;
        n = (m - pulses) & 3;
        repeat (n) begin
            mode_step = 1'b1; tick(); mode_step = 1'b0; tick();
        end
        do tick(); while (c % FT != 2);
    endtask

    task automatic test_reset();
        @(negedge clk);
        mode_step = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp += 8;
        if (vif.hs !== ~HPOL) begin n_fail++; $display("FAIL reset_hs got %b want %b", vif.hs, ~HPOL); end
        if (vif.vs !== ~VPOL) begin n_fail++; $display("FAIL reset_vs got %b want %b", vif.vs, ~VPOL); end
        if (vif.de !== 1'b0) begin n_fail++; $display("FAIL reset_de got %b want 0", vif.de); end
        if (vif.rgb !== 8'h00) begin n_fail++; $display("FAIL reset_rgb got %h want 00", vif.rgb); end
        if (vif.addra !== 16'd0) begin n_fail++; $display("FAIL reset_addra got %0d want 0", vif.addra); end
        if (vif.addrb !== 16'(BB)) begin n_fail++; $display("FAIL reset_addrb got %0d want %0d", vif.addrb, BB); end
        if (mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode got %0d want 0", mode); end
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b want 0", frame_start); end
        repeat (2) @(negedge clk);
        rst = 1'b0; c = 0; pulses = 0;
        tick();
        n_cmp += 2;
        if (frame_start !== 1'b1) begin n_fail++; $display("FAIL first_fs got %b want 1", frame_start); end
        if (mode !== 2'd0) begin n_fail++; $display("FAIL post_reset_mode got %0d want 0", mode); end
    endtask

    task automatic test_sync(input int frames);
        logic ehs, evs, ede, efs;
        logic [7:0] ergb;
        repeat (frames * FT) begin
            tick();
            expect_at(c, ehs, evs, ede, ergb);
            efs = c % FT == 1;
            n_cmp += 4;
            if (vif.hs !== ehs) begin n_fail++; $display("FAIL sync_hs c=%0d got %b want %b", c, vif.hs, ehs); end
            if (vif.vs !== evs) begin n_fail++; $display("FAIL sync_vs c=%0d got %b want %b", c, vif.vs, evs); end
            if (vif.de !== ede) begin n_fail++; $display("FAIL sync_de c=%0d got %b want %b", c, vif.de, ede); end
            if (frame_start !== efs) begin n_fail++; $display("FAIL sync_fs c=%0d got %b want %b", c, frame_start, efs); end
        end
    endtask

    task automatic test_mode0();
        logic ehs, evs, ede;
        logic [7:0] ergb;
        nxt_wx = 20; nxt_wy = 10;
        goto_mode(0);
        repeat (2 * FT) begin
            tick();
            expect_at(c, ehs, evs, ede, ergb);
            n_cmp += 2;
            if (vif.de !== ede) begin n_fail++; $display("FAIL m0_de c=%0d got %b want %b", c, vif.de, ede); end
            if (vif.rgb !== ergb) begin n_fail++; $display("FAIL m0_rgb c=%0d got %h want %h", c, vif.rgb, ergb); end
            if (c % FT == 0) begin
                n_cmp++;
                if (vif.addra !== 16'(last_a(c / FT - 1))) begin
                    n_fail++; $display("FAIL m0_addra_last c=%0d got %0d want %0d", c, vif.addra, last_a(c / FT - 1));
                end
            end
            if (c % FT == 2) begin
                n_cmp++;
                if (vif.addra !== 16'd0) begin n_fail++; $display("FAIL m0_addra_zero c=%0d got %0d want 0", c, vif.addra); end
            end
        end
    endtask

    task automatic test_mode1();
        logic ehs, evs, ede;
        logic [7:0] ergb;
        int h, v;
        nxt_wx = $urandom_range(0, HA); nxt_wy = $urandom_range(0, VA);
        goto_mode(1);
        repeat (FT) begin
            tick();
            expect_at(c, ehs, evs, ede, ergb);
            n_cmp++;
            if (vif.rgb !== ergb) begin n_fail++; $display("FAIL m1_rgb c=%0d got %h want %h", c, vif.rgb, ergb); end
            h = (c - 1) % HT; v = ((c - 1) / HT) % VT;
            if (h == HS + HB + 9 && v == VS + VB + 17) begin
                n_cmp++;
                if (vif.addrb !== 16'd150) begin n_fail++; $display("FAIL m1_addrb_9_17 got %0d want 150", vif.addrb); end
            end
        end
    endtask

    task automatic test_mode_step();
        logic ehs, evs, ede;
        logic [7:0] ergb, em;
        int off;
        nxt_wx = 5; nxt_wy = 3;
        repeat (4 * FT) begin
            off = c % FT;
            mode_step = ((c / FT) % 2 == 0 && off == 1) || ((c / FT) % 2 == 1 && off == 0) ||
                        $urandom_range(0, 699) == 0;
            tick();
            mode_step = 1'b0;
            expect_at(c, ehs, evs, ede, ergb);
            em = 8'(exp_mode(c));
            n_cmp += 2;
            if (mode !== em[1:0]) begin n_fail++; $display("FAIL step_mode c=%0d got %0d want %0d", c, mode, em[1:0]); end
            if (vif.rgb !== ergb) begin n_fail++; $display("FAIL step_rgb c=%0d got %h want %h", c, vif.rgb, ergb); end
        end
    endtask

    task automatic test_clip(input int wx, input int wy, input int m);
        logic ehs, evs, ede;
        logic [7:0] ergb;
        nxt_wx = wx; nxt_wy = wy;
        goto_mode(m);
        repeat (FT) begin
            tick();
            expect_at(c, ehs, evs, ede, ergb);
            n_cmp += 2;
            if (vif.rgb !== ergb) begin n_fail++; $display("FAIL clip_rgb c=%0d got %h want %h", c, vif.rgb, ergb); end
            if (mode !== exp_mode(c)) begin n_fail++; $display("FAIL clip_mode c=%0d got %0d want %0d", c, mode, exp_mode(c)); end
            if (c % FT == 0) begin
                n_cmp++;
                if (vif.addra !== 16'(last_a(c / FT - 1))) begin
                    n_fail++; $display("FAIL clip_addra_last c=%0d got %0d want %0d", c, vif.addra, last_a(c / FT - 1));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sync(2);
        test_mode0();
        test_mode1();
        test_mode_step();
        test_clip(HA - 4, VA - 3, 2);
        repeat (2) test_clip($urandom_range(0, HA + 4), $urandom_range(0, VA + 2), $urandom_range(0, 3));
        mode_step = 1'b1; tick(); mode_step = 1'b0;
        repeat (700) tick();
        test_reset();
        test_sync(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
